// File: rtl/pipe_pkg.sv
// Shared M-stage definitions: Funct3 access-size codes,
// the memory-access FSM state type and a size decoder.
package pipe_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mau_state_t;

    // Unknown encodings fall back to a full-word access.
    function automatic acc_size_t f3_size(input logic [2:0] f3);
        acc_size_t sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension of the
// returned memory word.
module load_extend
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            addr_lo_i,
    input  logic [2:0]            funct3_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sext;

    // Pick the addressed lane, then extend it to a full word.
    always_comb begin
        byte_v = 8'h00;
        half_v = 16'h0000;
        sext   = ~funct3_i[2];
        data_o = rdata_i;
        unique case (addr_lo_i)
            2'd0: byte_v = rdata_i[7:0];
            2'd1: byte_v = rdata_i[15:8];
            2'd2: byte_v = rdata_i[23:16];
            2'd3: byte_v = rdata_i[31:24];
        endcase
        half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        unique case (f3_size(funct3_i))
            SZ_B:    data_o = {{24{sext & byte_v[7]}}, byte_v};
            SZ_H:    data_o = {{16{sext & half_v[15]}}, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// M-stage data-memory access FSM (IDLE/WAIT/DONE) with stall.
// Optional misaligned-access trap: define MISALIGN_CHECK_EN.
module memory_access_unit
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   ALUResultM,
    input  logic [DATA_WIDTH-1:0]   WriteDataM,
    input  logic                    MemReadM,
    input  logic                    MemWriteM,
    input  logic [2:0]              Funct3M,
    output logic                    dmem_req_valid,
    output logic                    dmem_req_we,
    output logic [DATA_WIDTH-1:0]   dmem_addr,
    output logic [DATA_WIDTH-1:0]   dmem_wdata,
    output logic [DATA_WIDTH/8-1:0] dmem_wstrb,
    input  logic                    dmem_req_ready,
    input  logic                    dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata,
    output logic [DATA_WIDTH-1:0]   MemDataM,
    output logic                    StallM,
    output logic                    MisalignM
);

    mau_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  mem_op;
    logic                  misalign;
    logic                  req_valid;
    logic                  stall;
    logic                  mis_flag;

    assign mem_op    = MemReadM | MemWriteM;
    assign dmem_addr = {ALUResultM[DATA_WIDTH-1:2], 2'b00};

    load_extend #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_extend (
        .rdata_i  (dmem_rdata),
        .addr_lo_i(ALUResultM[1:0]),
        .funct3_i (Funct3M),
        .data_o   (load_data)
    );

`ifdef MISALIGN_CHECK_EN
    // Flag halfword/word accesses not on their natural boundary.
    always_comb begin
        misalign = 1'b0;
        unique case (f3_size(Funct3M))
            SZ_H:    misalign = ALUResultM[0];
            SZ_W:    misalign = |ALUResultM[1:0];
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Store byte enables and lane-replicated write data.
    always_comb begin
        dmem_wstrb = 4'b1111;
        dmem_wdata = WriteDataM;
        unique case (f3_size(Funct3M))
            SZ_B: begin
                dmem_wstrb = 4'b0001 << ALUResultM[1:0];
                dmem_wdata = {4{WriteDataM[7:0]}};
            end
            SZ_H: begin
                dmem_wstrb = ALUResultM[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                dmem_wstrb = 4'b1111;
                dmem_wdata = WriteDataM;
            end
        endcase
    end

    // Next state, load capture and handshake/stall outputs.
    always_comb begin
        state_d    = state_q;
        mem_data_d = mem_data_q;
        req_valid  = 1'b0;
        stall      = 1'b0;
        mis_flag   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (misalign) begin
                        mis_flag   = 1'b1;
                        mem_data_d = '0;
                    end else begin
                        req_valid = 1'b1;
                        stall     = 1'b1;
                        if (dmem_req_ready) begin
                            state_d = MemWriteM ? DONE : WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dmem_rsp_valid) begin
                    mem_data_d = load_data;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held.
    assign dmem_req_valid = req_valid & rst;
    assign dmem_req_we    = req_valid & rst & MemWriteM;
    assign StallM         = stall & rst;
    assign MisalignM      = mis_flag & rst;
    assign MemDataM       = mem_data_q;

    // State and load-result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_data_q <= mem_data_d;
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: vector table,
// directed corner sequences and randomized ops vs. a model.
`timescale 1ns/1ps
module tb_memory_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic        dmem_req_valid;
    logic        dmem_req_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_req_ready;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic [31:0] MemDataM;
    logic        StallM;
    logic        MisalignM;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_data;

    memory_access_unit #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ALUResultM    (ALUResultM),
        .WriteDataM    (WriteDataM),
        .MemReadM      (MemReadM),
        .MemWriteM     (MemWriteM),
        .Funct3M       (Funct3M),
        .dmem_req_valid(dmem_req_valid),
        .dmem_req_we   (dmem_req_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_wstrb    (dmem_wstrb),
        .dmem_req_ready(dmem_req_ready),
        .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rdata    (dmem_rdata),
        .MemDataM      (MemDataM),
        .StallM        (StallM),
        .MisalignM     (MisalignM)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Access size in bytes.
    function automatic int nbytes(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ld_fmt(input logic [31:0] a,
                                           input logic [2:0] f3,
                                           input logic [31:0] rd);
        int          n;
        int          off;
        logic [31:0] v;
        n = nbytes(f3);
        if (n == 4) return rd;
        off = (n == 1) ? int'(a[1:0]) : 2 * int'(a[1]);
        v = rd >> (8 * off);
        if (n == 1) begin
            v = v & 32'h0000_00FF;
            if (f3 == 3'b000 && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else begin
            v = v & 32'h0000_FFFF;
            if (f3 == 3'b001 && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] st_strb(input logic [31:0] a,
                                           input logic [2:0] f3);
        int n;
        n = nbytes(f3);
        if (n == 1) return 4'(1 << int'(a[1:0]));
        if (n == 2) return 4'(3 << (2 * int'(a[1])));
        return 4'hF;
    endfunction

    function automatic logic [31:0] st_data(input logic [31:0] wd,
                                            input logic [2:0] f3);
        int n;
        n = nbytes(f3);
        if (n == 1) return {24'h0, wd[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'h0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic bit is_misaligned(input logic [31:0] a,
                                         input logic [2:0] f3);
`ifdef MISALIGN_CHECK_EN
        int n;
        n = nbytes(f3);
        return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`else
        return (a[31:0] == 32'hFFFF_FFFF) && (f3 == 3'b111) && 1'b0;
`endif
    endfunction

    // One complete op: request held rdy_dly cycles unaccepted,
    // load response rsp_dly cycles after entering the wait phase.
    task automatic run_op(input bit st, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input logic [31:0] rd, input int rdy_dly,
                          input int rsp_dly, output int stalls);
        int n;
        n = st ? rdy_dly + 1 : rdy_dly + rsp_dly + 2;
        stalls = 0;
        MemReadM = st ? 1'($urandom) : 1'b1;
        MemWriteM = st;
        ALUResultM = a;
        WriteDataM = wd;
        Funct3M = f3;
        if (is_misaligned(a, f3)) begin
            dmem_req_ready = 1'($urandom);
            dmem_rsp_valid = 1'b0;
            @(negedge clk);
            chk("mis_flag", 32'(MisalignM), 32'd1);
            chk("mis_valid", 32'(dmem_req_valid), 32'd0);
            chk("mis_stall", 32'(StallM), 32'd0);
            @(posedge clk);
            #1;
            MemReadM = 1'b0;
            MemWriteM = 1'b0;
            model_data = 32'h0;
            @(negedge clk);
            chk("mis_data", MemDataM, 32'h0);
            chk("mis_flag_clr", 32'(MisalignM), 32'd0);
            @(posedge clk);
            #1;
            return;
        end
        for (int c = 0; c <= n; c++) begin
            if (c <= rdy_dly) dmem_req_ready = (c == rdy_dly);
            else dmem_req_ready = 1'($urandom);
            if (!st && c == n - 1) begin
                dmem_rsp_valid = 1'b1;
                dmem_rdata = rd;
            end else if (!st && c > rdy_dly) begin
                dmem_rsp_valid = 1'b0;
                dmem_rdata = $urandom;
            end else begin
                dmem_rsp_valid = 1'($urandom);
                dmem_rdata = $urandom;
            end
            @(negedge clk);
            if (StallM) stalls++;
            chk("stall", 32'(StallM), 32'(c < n));
            chk("req_valid", 32'(dmem_req_valid), 32'(c <= rdy_dly));
            chk("misalign", 32'(MisalignM), 32'd0);
            if (c <= rdy_dly) begin
                chk("addr", dmem_addr, {a[31:2], 2'b00});
                chk("we", 32'(dmem_req_we), 32'(st));
                if (st) begin
                    chk("wstrb", 32'(dmem_wstrb), 32'(st_strb(a, f3)));
                    chk("wdata", dmem_wdata, st_data(wd, f3));
                end
            end
            if (c == n) begin
                if (!st) model_data = ld_fmt(a, f3, rd);
                chk("memdata", MemDataM, model_data);
            end else begin
                chk("memdata_hold", MemDataM, model_data);
            end
            @(posedge clk);
            #1;
        end
        MemReadM = 1'b0;
        MemWriteM = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t vecs[9];

    initial begin
        int stl;
        vecs[0] = '{32'h103, 3'b000, 32'h80FF_0000, 32'hFFFF_FF80};
        vecs[1] = '{32'h103, 3'b100, 32'h80FF_0000, 32'h0000_0080};
        vecs[2] = '{32'h102, 3'b001, 32'h80FF_0000, 32'hFFFF_80FF};
        vecs[3] = '{32'h102, 3'b101, 32'h80FF_0000, 32'h0000_80FF};
        vecs[4] = '{32'h101, 3'b000, 32'h1234_5678, 32'h0000_0056};
        vecs[5] = '{32'h100, 3'b001, 32'h1234_F678, 32'hFFFF_F678};
        vecs[6] = '{32'h104, 3'b010, 32'hCAFE_BABE, 32'hCAFE_BABE};
        vecs[7] = '{32'h100, 3'b011, 32'h89AB_CDEF, 32'h89AB_CDEF};
        vecs[8] = '{32'h100, 3'b100, 32'h0000_00FF, 32'h0000_00FF};

        rst = 1'b0;
        ALUResultM = 32'h100;
        WriteDataM = 32'h0;
        MemReadM = 1'b1;
        MemWriteM = 1'b0;
        Funct3M = 3'b010;
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b0;
        dmem_rdata = 32'h0;
        model_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(StallM), 32'd0);
        chk("rst_valid", 32'(dmem_req_valid), 32'd0);
        chk("rst_data", MemDataM, 32'h0);
        chk("rst_mis", 32'(MisalignM), 32'd0);
        MemReadM = 1'b0;
        dmem_req_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("idle_stall", 32'(StallM), 32'd0);
        chk("idle_valid", 32'(dmem_req_valid), 32'd0);
        @(posedge clk);
        #1;

        // LW 0x100, accepted at once, response next cycle.
        run_op(1'b0, 32'h100, 32'h0, 3'b010, 32'hDEAD_BEEF, 0, 0, stl);
        chk("lw_stall_cycles", 32'(stl), 32'd2);
        @(negedge clk);
        chk("lw_data", MemDataM, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_op(1'b0, vecs[i].addr, 32'h0, vecs[i].f3, vecs[i].rdata,
                   0, 0, stl);
            @(negedge clk);
            chk($sformatf("vec%0d_data", i), MemDataM, vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // SH 0x102 held off by memory for three cycles.
        MemReadM = 1'b0;
        MemWriteM = 1'b1;
        ALUResultM = 32'h102;
        WriteDataM = 32'h1234_ABCD;
        Funct3M = 3'b001;
        dmem_req_ready = 1'b0;
        @(negedge clk);
        chk("sh_wstrb", 32'(dmem_wstrb), 32'b1100);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        chk("sh_we", 32'(dmem_req_we), 32'd1);
        chk("sh_stall", 32'(StallM), 32'd1);
        @(posedge clk);
        #1;
        run_op(1'b1, 32'h102, 32'h1234_ABCD, 3'b001, 32'h0, 2, 0, stl);
        chk("sh_stall_cycles", 32'(stl), 32'd3);

        // Spurious response while idle, then reset during WAIT.
        run_op(1'b0, 32'h200, 32'h0, 3'b010, 32'h1122_3344, 0, 1, stl);
        dmem_rsp_valid = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        repeat (2) begin
            @(negedge clk);
            chk("spur_stall", 32'(StallM), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("spur_data", MemDataM, 32'h1122_3344);
        @(posedge clk);
        #1;
        dmem_rsp_valid = 1'b0;
        MemReadM = 1'b1;
        ALUResultM = 32'h204;
        Funct3M = 3'b010;
        dmem_req_ready = 1'b1;
        @(negedge clk);
        chk("rw_req", 32'(dmem_req_valid), 32'd1);
        @(posedge clk);
        #1;
        dmem_req_ready = 1'b0;
        @(negedge clk);
        chk("rw_wait_stall", 32'(StallM), 32'd1);
        chk("rw_wait_valid", 32'(dmem_req_valid), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("rw_rst_stall", 32'(StallM), 32'd0);
        chk("rw_rst_data", MemDataM, 32'h0);
        chk("rw_rst_valid", 32'(dmem_req_valid), 32'd0);
        MemReadM = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rdata = 32'h5555_5555;
        @(negedge clk);
        chk("rw_post_stall", 32'(StallM), 32'd0);
        @(posedge clk);
        #1;
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("rw_no_stale", MemDataM, 32'h0);
        @(posedge clk);
        #1;
        model_data = 32'h0;

        // Misaligned word load.
        run_op(1'b0, 32'h101, 32'h0, 3'b010, 32'h0BAD_F00D, 0, 0, stl);
        @(negedge clk);
`ifdef MISALIGN_CHECK_EN
        chk("lw_mis_data", MemDataM, 32'h0);
`else
        chk("lw_unal_data", MemDataM, 32'h0BAD_F00D);
`endif
        @(posedge clk);
        #1;

        for (int k = 0; k < 40; k++) begin
            run_op(1'($urandom), $urandom, $urandom,
                   3'($urandom_range(0, 7)), $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   stl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath and address width; only 32 is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 ALUResultM  input  32  effective byte address of the M-stage instruction.
REQ-005 WriteDataM  input  32  store data, right-aligned.
REQ-006 MemReadM / MemWriteM  input  1 each  load / store request.
REQ-007 Funct3M  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 dmem_req_valid, dmem_req_we  output  1 each  request valid and write-enable.
REQ-009 dmem_addr  output  32  word-aligned address, ALUResultM with [1:0] forced to 00.
REQ-010 dmem_wdata  output  32  lane-replicated store data; dmem_wstrb  output  4  byte enables.
REQ-011 dmem_req_ready, dmem_rsp_valid  input  1 each; dmem_rdata  input  32  read word.
REQ-012 MemDataM  output  32  formatted load result, sent to the M/W register.
REQ-013 StallM  output  1  freezes the PC and all upstream pipe registers while high.
REQ-014 MisalignM  output  1  one-cycle misaligned-access flag.

Function
REQ-015 FSM states: IDLE, WAIT, DONE.
REQ-016 IDLE, no memory op:
- no request; StallM=0.
- MemDataM holds its last value.
REQ-017 IDLE, memory op present:
- dmem_req_valid=1, combinational in the same cycle; StallM=1.
- dmem_req_we=1 when MemWriteM=1.
REQ-018 IDLE on request acceptance (dmem_req_ready=1): store goes to DONE; load goes to WAIT.
REQ-019 WAIT:
- dmem_req_valid=0, StallM=1.
- On dmem_rsp_valid=1, register the formatted dmem_rdata into MemDataM and go to DONE.
REQ-020 DONE: StallM=0 for exactly one cycle, then unconditionally go to IDLE; the pipeline advances on that edge.
REQ-021 Minimum occupancy: store 2 cycles (IDLE, DONE); load 3 cycles (IDLE, WAIT, DONE). A new op is evaluated in the IDLE cycle that follows DONE.
REQ-022 Upstream holds all M-stage inputs stable while StallM=1; the outputs depend on that stability.
REQ-023 MemReadM and MemWriteM both 1: treated as a store.
REQ-024 dmem_rsp_valid outside WAIT is ignored; dmem_req_ready outside IDLE is ignored.
REQ-025 Load formatting:
- Byte lane is addr[1:0]; halfword lane is addr[1].
- B and H sign-extend; BU and HU zero-extend; W passes through.
- Any other Funct3M is treated as W.
REQ-026 Store strobes:
- SB: wstrb = 0001 << addr[1:0].
- SH: wstrb = 0011 << (2*addr[1]).
- SW and others: wstrb = 1111.
- wdata replicates the byte or halfword across all lanes.

Reset
REQ-027 rst low sets state IDLE, MemDataM=0, StallM=0, dmem_req_valid=0, MisalignM=0.
REQ-028 Reset asserted mid-operation abandons the transaction; a later dmem_rsp_valid is ignored.

Configuration
REQ-029 Macro MISALIGN_CHECK_EN controls misaligned-access detection.
REQ-030 With MISALIGN_CHECK_EN defined, in IDLE:
- An H/HU access with addr[0]=1, or a W access with addr[1:0]!=00, issues no request.
- It drives MisalignM=1 and StallM=0 for that cycle and sets MemDataM=0.
- It then stays in IDLE.
REQ-031 Without MISALIGN_CHECK_EN, MisalignM is tied 0; address bits below the access size are ignored for lane selection.

Structure
REQ-032 Shared package pipe_pkg holds:
- the Funct3 size localparams;
- the FSM state enum mau_state_t.
REQ-033 One combinational sub-module, load_extend, performs lane select and extension (REQ-025); the store strobe logic stays inline.

Verification
REQ-034 LW at 0x100, ready=1 in cycle 0, rsp in cycle 1 with 0xDEADBEEF -> StallM high for 2 cycles, MemDataM=0xDEADBEEF in DONE.
REQ-035 LB at 0x103, rdata 0x80FF_0000 -> MemDataM=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-036 SH at 0x102 with WriteDataM=0x1234ABCD -> wstrb=1100, wdata=0xABCDABCD, we=1; dmem_req_ready held low 3 cycles -> StallM stays high until acceptance.
REQ-037 Spurious dmem_rsp_valid in IDLE, then rst low during WAIT -> MemDataM unchanged by the spurious response; after reset, state IDLE, MemDataM=0, no stale capture.
REQ-038 MISALIGN_CHECK_EN defined, LW at 0x101 -> no dmem_req_valid, MisalignM=1 for 1 cycle, StallM=0, MemDataM=0.
